bcd_scan_display: RTL and testbench

Parametrised multi-digit BCD event counter with a time-multiplexed seven-segment scan driver, for the Vaman FPGA display board. It counts single-cycle increment pulses in decimal across NUM_DIGITS digits and drives one shared segment bus plus per-digit enables. It sits between the board's pulse sources (debounced button or sensor strobe) and the display pins, and replaces per-digit combinational decoders.

---
 rtl/bcd_scan_display.sv | 141 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module     : bcd_scan_display
// Description: Multi-digit BCD event counter with a time-multiplexed
//              seven-segment scan driver (shared segment bus + one-hot enables).
//              Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision   : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PRE_W-1:0]    c_PRE_TC   = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_SEL_W-1:0]    c_SEL_LAST = c_SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_RST   = NUM_DIGITS'(1);
    localparam logic [6:0]            c_SEG_RST  = 7'b0111111;

    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    wrap_q, wrap_d;
    logic [c_PRE_W-1:0]      presc_q, presc_d;
    logic [c_SEL_W-1:0]      sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    w_tick;
    logic                    w_blank;
    logic [3:0]              w_digit;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Carry ripples through every digit within the same cycle.
    always_comb begin : p_count
        logic carry;
        bcd_d  = bcd_q;
        carry  = inc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (bcd_q[4*k +: 4] == 4'd9) begin
                    bcd_d[4*k +: 4] = 4'd0;
                end else begin
                    bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        wrap_d = carry;
        if (clr) begin
            bcd_d  = '0;
            wrap_d = 1'b0;
        end
    end

    always_comb begin
        w_tick  = (presc_q == c_PRE_TC);
        presc_d = w_tick ? '0 : presc_q + 1'b1;
        sel_d   = sel_q;
        if (w_tick) begin
            sel_d = (sel_q == c_SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin : p_display
        logic zero_run;
        w_digit  = 4'd0;
        an_d     = '0;
        w_blank  = 1'b0;
        zero_run = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_q == c_SEL_W'(k)) begin
                w_digit  = bcd_q[4*k +: 4];
                an_d[k]  = 1'b1;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Digit k>0 is blank when it and every digit above it are zero.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
            if ((sel_q == c_SEL_W'(k)) && zero_run) begin
                w_blank = 1'b1;
            end
        end
`else
        zero_run = 1'b0;
        w_blank  = zero_run;
`endif
        seg_d = w_blank ? 7'b0000000 : f_decode(w_digit);
    end

    // rst_n release is expected to arrive already synchronised to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
            sel_q   <= '0;
            seg_q   <= c_SEG_RST;
            an_q    <= c_AN_RST;
        end else begin
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bcd  = bcd_q;
    assign wrap = wrap_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module     : tb_bcd_scan_display
// Description: Directed self-checking bench for bcd_scan_display (4 digits,
//              4-cycle scan slots); blanking expectations follow
//              LEADING_ZERO_BLANK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam int c_N   = 4;
    localparam int c_DIV = 4;

    logic             clk;
    logic             rst_n;
    logic             inc;
    logic             clr;
    logic [4*c_N-1:0] bcd;
    logic             wrap;
    logic [6:0]       seg;
    logic [c_N-1:0]   an;

    int errors = 0;
    int checks = 0;

    logic [6:0] exp1234  [4];
    logic [6:0] exp0007  [4];

    bcd_scan_display #(.NUM_DIGITS(c_N), .SCAN_DIV(c_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .clr   (clr),
        .bcd   (bcd),
        .wrap  (wrap),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until an has just switched back to digit 0.
    task automatic align_scan();
        logic [c_N-1:0] prev;
        logic           found;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (prev != 4'b0001 && an == 4'b0001) found = 1'b1;
            prev = an;
        end
        chk("align_timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [3:0] an_exp;
        exp1234 = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
`ifdef LEADING_ZERO_BLANK_EN
        exp0007 = '{7'b0000111, 7'b0000000, 7'b0000000, 7'b0000000};
`else
        exp0007 = '{7'b0000111, 7'b0111111, 7'b0111111, 7'b0111111};
`endif
        rst_n = 1'b0;
        inc   = 1'b0;
        clr   = 1'b0;
        step();
        step();
        chk("rst_bcd",  {16'd0, bcd}, 32'h0);
        chk("rst_wrap", {31'd0, wrap}, 32'h0);
        chk("rst_an",   {28'd0, an}, 32'h1);
        chk("rst_seg",  {25'd0, seg}, 32'h3F);
        rst_n = 1'b1;

        // Count to 42, then clr together with inc.
        inc = 1'b1;
        repeat (42) step();
        inc = 1'b0;
        chk("cnt42", {16'd0, bcd}, 32'h0042);
        inc = 1'b1;
        clr = 1'b1;
        step();
        inc = 1'b0;
        clr = 1'b0;
        chk("clr_inc_bcd",  {16'd0, bcd}, 32'h0000);
        chk("clr_inc_wrap", {31'd0, wrap}, 32'h0);

        // 0099 + inc -> 0100 without wrap.
        inc = 1'b1;
        repeat (99) step();
        inc = 1'b0;
        chk("cnt99", {16'd0, bcd}, 32'h0099);
        inc = 1'b1;
        step();
        inc = 1'b0;
        chk("cnt100",      {16'd0, bcd}, 32'h0100);
        chk("cnt100_wrap", {31'd0, wrap}, 32'h0);

        // Full ripple and wrap.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_bcd", {16'd0, bcd}, 32'h0000);
        inc = 1'b1;
        repeat (9999) step();
        chk("cnt9999",      {16'd0, bcd}, 32'h9999);
        chk("cnt9999_wrap", {31'd0, wrap}, 32'h0);
        step();
        inc = 1'b0;
        chk("wrap_bcd",   {16'd0, bcd}, 32'h0000);
        chk("wrap_pulse", {31'd0, wrap}, 32'h1);
        step();
        chk("wrap_end",     {31'd0, wrap}, 32'h0);
        chk("wrap_end_bcd", {16'd0, bcd}, 32'h0000);

        // Blanking / leading zeros at 0007.
        inc = 1'b1;
        repeat (7) step();
        inc = 1'b0;
        chk("cnt7", {16'd0, bcd}, 32'h0007);
        align_scan();
        for (int s = 0; s < 4; s++) begin
            chk("blank_seg", {25'd0, seg}, {25'd0, exp0007[s]});
            repeat (c_DIV) step();
        end

        // Scan pattern at 1234.
        clr = 1'b1;
        step();
        clr = 1'b0;
        inc = 1'b1;
        repeat (1234) step();
        inc = 1'b0;
        chk("cnt1234", {16'd0, bcd}, 32'h1234);
        align_scan();
        for (int s = 0; s < 4; s++) begin
            an_exp = 4'b0001 << s;
            for (int c = 0; c < c_DIV; c++) begin
                chk("scan_an",  {28'd0, an}, {28'd0, an_exp});
                chk("scan_seg", {25'd0, seg}, {25'd0, exp1234[s]});
                step();
            end
        end
        chk("scan_an_rewind", {28'd0, an}, 32'h1);

        // Asynchronous reset in the middle of a scan slot.
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bcd", {16'd0, bcd}, 32'h0);
        chk("arst_an",  {28'd0, an}, 32'h1);
        chk("arst_seg", {25'd0, seg}, 32'h3F);
        step();
        rst_n = 1'b1;
        repeat (c_DIV) step();
        chk("post_rst_an_hold", {28'd0, an}, 32'h1);
        step();
        chk("post_rst_an_adv",  {28'd0, an}, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
